// File: rtl/interconnect_pkg.sv
// Shared constants for the interconnect controller: one-hot state codes,
// FIFO flag bit positions and the default threshold width.
package interconnect_pkg;

  localparam int PTR_L_DEF = 5;
  localparam int N_FIFO    = 5;

  // Bit positions inside fifo_empty / fifo_error / errors
  localparam int FIFO_MAIN = 0;
  localparam int FIFO_VC0  = 1;
  localparam int FIFO_VC1  = 2;
  localparam int FIFO_D0   = 3;
  localparam int FIFO_D1   = 4;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

endpackage

// File: rtl/umbral_regs.sv
// Six FIFO threshold registers; they capture the candidate values on every
// edge while load is high and hold otherwise.
module umbral_regs
  import interconnect_pkg::*;
#(
  parameter int PTR_L = PTR_L_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PTR_L-1:0] m_full_in,
  input  logic [PTR_L-1:0] m_empty_in,
  input  logic [PTR_L-1:0] v_full_in,
  input  logic [PTR_L-1:0] v_empty_in,
  input  logic [PTR_L-1:0] d_full_in,
  input  logic [PTR_L-1:0] d_empty_in,
  output logic [PTR_L-1:0] m_full,
  output logic [PTR_L-1:0] m_empty,
  output logic [PTR_L-1:0] v_full,
  output logic [PTR_L-1:0] v_empty,
  output logic [PTR_L-1:0] d_full,
  output logic [PTR_L-1:0] d_empty
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_full  <= '0;
      m_empty <= '0;
      v_full  <= '0;
      v_empty <= '0;
      d_full  <= '0;
      d_empty <= '0;
    end else if (load) begin
      m_full  <= m_full_in;
      m_empty <= m_empty_in;
      v_full  <= v_full_in;
      v_empty <= v_empty_in;
      d_full  <= d_full_in;
      d_empty <= d_empty_in;
    end
  end

endmodule

// File: rtl/interconnect_ctrl.sv
// Interconnect sequencing FSM: configures FIFO thresholds, tracks activity and
// latches FIFO errors. Optional macro UMBRAL_CHECK_EN rejects full<=empty pairs.
//
// state  | meaning
// RESET  | just out of reset, nothing configured
// INIT   | thresholds follow the *_in inputs while init is held
// IDLE   | configured, every FIFO empty
// ACTIVE | configured, at least one FIFO holds data
// ERROR  | FIFO error or bad thresholds seen; only reset leaves
module interconnect_ctrl
  import interconnect_pkg::*;
#(
  parameter int PTR_L = PTR_L_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [PTR_L-1:0]  umbral_M_full_in,
  input  logic [PTR_L-1:0]  umbral_M_empty_in,
  input  logic [PTR_L-1:0]  umbral_V_full_in,
  input  logic [PTR_L-1:0]  umbral_V_empty_in,
  input  logic [PTR_L-1:0]  umbral_D_full_in,
  input  logic [PTR_L-1:0]  umbral_D_empty_in,
  input  logic [N_FIFO-1:0] fifo_empty,
  input  logic [N_FIFO-1:0] fifo_error,
  output logic [PTR_L-1:0]  umbral_M_full,
  output logic [PTR_L-1:0]  umbral_M_empty,
  output logic [PTR_L-1:0]  umbral_V_full,
  output logic [PTR_L-1:0]  umbral_V_empty,
  output logic [PTR_L-1:0]  umbral_D_full,
  output logic [PTR_L-1:0]  umbral_D_empty,
  output logic [4:0]        state,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out,
  output logic [N_FIFO-1:0] errors
);

  state_t            state_q, state_d;
  logic [N_FIFO-1:0] errors_q;
  logic              all_empty;
  logic              any_error;
  logic              thr_bad;

  assign all_empty = fifo_empty[FIFO_MAIN] & fifo_empty[FIFO_VC0] & fifo_empty[FIFO_VC1]
                   & fifo_empty[FIFO_D0] & fifo_empty[FIFO_D1];
  assign any_error = |fifo_error;

  // Checked against the values being loaded on the exit edge, i.e. the final configuration
`ifdef UMBRAL_CHECK_EN
  assign thr_bad = (umbral_M_full_in <= umbral_M_empty_in)
                 | (umbral_V_full_in <= umbral_V_empty_in)
                 | (umbral_D_full_in <= umbral_D_empty_in);
`else
  assign thr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) state_d = thr_bad ? ST_ERROR : ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (any_error)      state_d = ST_ERROR;
        else if (init)      state_d = ST_INIT;
        else if (all_empty) state_d = ST_IDLE;
        else                state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  errors_q <= '0;
    else if (state_q != ST_RESET) errors_q <= errors_q | fifo_error;
  end

  umbral_regs #(.PTR_L(PTR_L)) u_umbral_regs (
    .clk        (clk),
    .reset      (reset),
    .load       (state_q == ST_INIT),
    .m_full_in  (umbral_M_full_in),
    .m_empty_in (umbral_M_empty_in),
    .v_full_in  (umbral_V_full_in),
    .v_empty_in (umbral_V_empty_in),
    .d_full_in  (umbral_D_full_in),
    .d_empty_in (umbral_D_empty_in),
    .m_full     (umbral_M_full),
    .m_empty    (umbral_M_empty),
    .v_full     (umbral_V_full),
    .v_empty    (umbral_V_empty),
    .d_full     (umbral_D_full),
    .d_empty    (umbral_D_empty)
  );

  assign state      = state_q;
  assign errors     = errors_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_interconnect_ctrl.sv
// Bench for interconnect_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_interconnect_ctrl;

  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [4:0] mfi, mei, vfi, vei, dfi, dei;
  logic [4:0] fifo_empty, fifo_error;
  logic [4:0] mf, me, vf, ve, df, de;
  logic [4:0] state, errs;
  logic       idle_o, active_o, error_o;

  int n_checks = 0;
  int n_errors = 0;

  int         m_st;
  logic [4:0] m_errs;
  logic [4:0] m_thr [6];

  always #5 clk = ~clk;

  interconnect_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .init              (init),
    .umbral_M_full_in  (mfi),
    .umbral_M_empty_in (mei),
    .umbral_V_full_in  (vfi),
    .umbral_V_empty_in (vei),
    .umbral_D_full_in  (dfi),
    .umbral_D_empty_in (dei),
    .fifo_empty        (fifo_empty),
    .fifo_error        (fifo_error),
    .umbral_M_full     (mf),
    .umbral_M_empty    (me),
    .umbral_V_full     (vf),
    .umbral_V_empty    (ve),
    .umbral_D_full     (df),
    .umbral_D_empty    (de),
    .state             (state),
    .idle_out          (idle_o),
    .active_out        (active_o),
    .error_out         (error_o),
    .errors            (errs)
  );

  typedef struct {
    bit         rst;
    bit         ini;
    bit         alt;   // 1: drive all thresholds to 7 instead of the reference config
    logic [4:0] emp;
    logic [4:0] err;
    logic [4:0] exp_st;
    logic [4:0] exp_errs;
    logic [4:0] exp_mf;
    logic [4:0] exp_vf;
    logic [4:0] exp_de;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_thr(input logic [4:0] a, b, c, d, e, f);
    mfi = a; mei = b; vfi = c; vei = d; dfi = e; dei = f;
  endtask

  task automatic drive(input logic r, i, input logic [4:0] emp, err);
    reset = r; init = i; fifo_empty = emp; fifo_error = err;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [4:0] st, input logic [4:0] er,
                         input logic [29:0] thr);
    chk({name, "_state"}, state, st);
    chk({name, "_decode"}, {idle_o, active_o, error_o}, {st[2], st[3], st[4]});
    chk({name, "_errors"}, errs, er);
    chk({name, "_thr"}, {mf, me, vf, ve, df, de}, thr);
  endtask

  // Reference model: advance one clock edge using the inputs currently applied
  task automatic model_edge;
    logic [4:0] tin [6];
    int         nxt;
    bit         bad;
    tin = '{mfi, mei, vfi, vei, dfi, dei};
    bad = 1'b0;
    if (!reset) begin
      m_st   = S_RESET;
      m_errs = '0;
      foreach (m_thr[k]) m_thr[k] = '0;
    end else begin
`ifdef UMBRAL_CHECK_EN
      for (int k = 0; k < 3; k++) if (tin[2*k] <= tin[2*k+1]) bad = 1'b1;
`endif
      nxt = m_st;
      case (m_st)
        S_RESET: nxt = S_INIT;
        S_INIT: begin
          m_thr = tin;
          if (!init) nxt = bad ? S_ERROR : S_IDLE;
        end
        S_IDLE, S_ACTIVE: begin
          if (fifo_error != 0)         nxt = S_ERROR;
          else if (init)               nxt = S_INIT;
          else if (fifo_empty == 5'h1F) nxt = S_IDLE;
          else                         nxt = S_ACTIVE;
        end
        default: nxt = m_st;
      endcase
      if (m_st != S_RESET) m_errs = m_errs | fifo_error;
      m_st = nxt;
    end
  endtask

  initial begin
    logic [4:0] exp_oh;
    vecs[0] = '{1, 1, 0, 5'h1F, 5'h1F, 5'h02, 5'h00, 5'd0, 5'd0,  5'd0};
    vecs[1] = '{1, 1, 0, 5'h1F, 5'h00, 5'h02, 5'h00, 5'd3, 5'd15, 5'd1};
    vecs[2] = '{1, 0, 0, 5'h1F, 5'h00, 5'h04, 5'h00, 5'd3, 5'd15, 5'd1};
    vecs[3] = '{1, 0, 1, 5'h1E, 5'h00, 5'h08, 5'h00, 5'd3, 5'd15, 5'd1};
    vecs[4] = '{1, 0, 1, 5'h1F, 5'h00, 5'h04, 5'h00, 5'd3, 5'd15, 5'd1};
    vecs[5] = '{1, 0, 1, 5'h1E, 5'h00, 5'h08, 5'h00, 5'd3, 5'd15, 5'd1};
    vecs[6] = '{1, 1, 1, 5'h1E, 5'h08, 5'h10, 5'h08, 5'd3, 5'd15, 5'd1};
    vecs[7] = '{1, 1, 1, 5'h1E, 5'h00, 5'h10, 5'h08, 5'd3, 5'd15, 5'd1};
    vecs[8] = '{1, 0, 1, 5'h00, 5'h00, 5'h10, 5'h08, 5'd3, 5'd15, 5'd1};

    drive(1, 0, 5'h1F, 5'h00);
    set_thr(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1 chk_all("por", 5'h01, 5'h00, 30'd0);
    step();

    // Reset release, configuration load, activity tracking, error handling
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ini, vecs[i].emp, vecs[i].err);
      if (vecs[i].alt) set_thr(7, 7, 7, 7, 7, 7);
      else             set_thr(3, 1, 15, 1, 3, 1);
      step();
      chk($sformatf("vec%0d_state", i), state, vecs[i].exp_st);
      chk($sformatf("vec%0d_decode", i), {idle_o, active_o, error_o},
          {vecs[i].exp_st[2], vecs[i].exp_st[3], vecs[i].exp_st[4]});
      chk($sformatf("vec%0d_errors", i), errs, vecs[i].exp_errs);
      chk($sformatf("vec%0d_thr", i), {mf, vf, de}, {vecs[i].exp_mf, vecs[i].exp_vf, vecs[i].exp_de});
    end

    // Asynchronous reset between edges while in ERROR
    @(negedge clk);
    reset = 1'b0;
    #1 chk_all("async_rst", 5'h01, 5'h00, 30'd0);

    // Error arriving during INIT is recorded without leaving INIT
    step();
    drive(1, 1, 5'h1F, 5'h00);
    set_thr(3, 1, 15, 1, 3, 1);
    step();
    chk_all("init_entry", 5'h02, 5'h00, 30'd0);
    drive(1, 1, 5'h1F, 5'h01);
    step();
    chk_all("init_err", 5'h02, 5'h01, {5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1});
    drive(1, 0, 5'h1F, 5'h02);
    step();
    chk_all("init_exit_err", 5'h04, 5'h03, {5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1});
    step();
    chk_all("idle_err_held", 5'h10, 5'h03, {5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1});

    // Full threshold equal to empty threshold on INIT exit
    drive(0, 0, 5'h1F, 5'h00);
    step();
    drive(1, 1, 5'h1F, 5'h00);
    set_thr(1, 1, 15, 1, 3, 1);
    step();
    step();
    drive(1, 0, 5'h1F, 5'h00);
    step();
`ifdef UMBRAL_CHECK_EN
    chk_all("thr_check", 5'h10, 5'h00, {5'd1, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1});
`else
    chk_all("thr_nocheck", 5'h04, 5'h00, {5'd1, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1});
`endif

    // Randomized run against the reference model
    drive(0, 0, 5'h1F, 5'h00);
    step();
    model_edge();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(63) != 0);
      init       = ($urandom_range(5) == 0);
      fifo_error = ($urandom_range(19) == 0) ? 5'($urandom) : 5'h00;
      fifo_empty = ($urandom_range(1) == 0) ? 5'h1F : 5'($urandom);
      set_thr(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      @(posedge clk);
      model_edge();
      #1;
      exp_oh = 5'b00001 << m_st;
      chk("rnd_state", state, exp_oh);
      chk("rnd_decode", {idle_o, active_o, error_o},
          {m_st == S_IDLE, m_st == S_ACTIVE, m_st == S_ERROR});
      chk("rnd_errors", errs, m_errs);
      chk("rnd_thr", {mf, me, vf, ve, df, de},
          {m_thr[0], m_thr[1], m_thr[2], m_thr[3], m_thr[4], m_thr[5]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interconnect_ctrl.md
INTERCONNECT_CTRL -- requirements
Module: interconnect_ctrl

Interface
REQ-001 SHALL have parameter PTR_L, default 5: bit width of every FIFO threshold.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port init, input, 1 bit: request to enter or stay in configuration.
REQ-005 SHALL have ports umbral_M_full_in, umbral_M_empty_in, umbral_V_full_in, umbral_V_empty_in, umbral_D_full_in and umbral_D_empty_in, each input, PTR_L bits: candidate thresholds.
REQ-006 SHALL have port fifo_empty, input, 5 bits: empty flags, ordered {D1, D0, VC1, VC0, Main} from bit 4 down to bit 0.
REQ-007 SHALL have port fifo_error, input, 5 bits: per-FIFO overflow/underflow pulses, same ordering as fifo_empty.
REQ-008 SHALL have ports umbral_M_full, umbral_M_empty, umbral_V_full, umbral_V_empty, umbral_D_full and umbral_D_empty, each output, PTR_L bits: registered thresholds driven to the FIFOs.
REQ-009 SHALL have port state, output, 5 bits: one-hot state register.
REQ-010 SHALL have ports idle_out, active_out and error_out, each output, 1 bit: state decodes.
REQ-011 SHALL have port errors, output, 5 bits: sticky per-FIFO error record.

Function
REQ-012 SHALL implement a Moore FSM with one-hot states: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
REQ-013 SHALL move from RESET to INIT on the first rising clk edge with reset=1.
REQ-014 SHALL, in INIT, load all six *_in threshold values into the output registers on every edge, so they take effect one cycle after sampling.
REQ-015 SHALL stay in INIT while init=1, and SHALL move to IDLE on the first edge with init=0.
REQ-016 SHALL apply these transition rules in IDLE and ACTIVE, in priority order:
- any fifo_error bit set -> ERROR;
- else init=1 -> INIT;
- else fifo_empty==5'b11111 -> IDLE;
- else -> ACTIVE.
REQ-017 SHALL hold thresholds unchanged outside INIT.
REQ-018 SHALL remain in ERROR until reset; init SHALL NOT exit ERROR.
REQ-019 SHALL OR fifo_error into the errors register on every edge in every state except RESET, with no clearing except by reset.
REQ-020 SHALL decode outputs from the state register only: idle_out=IDLE, active_out=ACTIVE, error_out=ERROR; all three SHALL be 0 in RESET and INIT.
REQ-021 SHALL give priority to error when fifo_error and init are asserted in the same cycle.
REQ-022 SHALL record an error that arrives in INIT in errors without changing state; ERROR SHALL then be entered from IDLE on the next edge only if fifo_error is still asserted.

Reset
REQ-023 SHALL, while reset=0 and independent of clk, force state=RESET, errors=0, all six thresholds=0 and idle_out, active_out, error_out=0.
REQ-024 SHALL, if reset is asserted mid-operation in any state, discard all configuration and errors, and SHALL require a new INIT pass after release.

Configuration
REQ-025 SHALL support macro UMBRAL_CHECK_EN. When defined, on leaving INIT, if any full threshold is less than or equal to its paired empty threshold, the FSM SHALL go to ERROR (errors unchanged) instead of IDLE. When undefined, thresholds SHALL go unchecked and INIT SHALL always exit to IDLE.

Structure
REQ-026 SHALL take the state encodings, the FIFO index constants (MAIN=0 to D1=4) and the PTR_L default from a shared package, interconnect_pkg.
REQ-027 SHALL place the six threshold registers, with load-enable = (state==INIT), in one sub-module, umbral_regs.

Verification
REQ-028 SHALL verify reset release: reset 0->1 -> state INIT on edge 1, all outputs 0.
REQ-029 SHALL verify configuration load: init=1, M_full=3, M_empty=1, V_full=15, V_empty=1, D_full=3, D_empty=1, then init=0 -> those values on the outputs and idle_out=1 one edge after init drops.
REQ-030 SHALL verify activity tracking: in IDLE, fifo_empty=5'b11110 -> active_out=1 next edge; fifo_empty=5'b11111 -> idle_out=1 next edge.
REQ-031 SHALL verify error handling: in ACTIVE, fifo_error=5'b01000 for one cycle together with init=1 -> ERROR, errors=5'b01000, which persists after fifo_error clears; init=1 -> still ERROR.
REQ-032 SHALL verify asynchronous reset: reset=0 between clock edges while in ERROR -> state=RESET and errors=0 immediately.
REQ-033 SHALL verify, with UMBRAL_CHECK_EN defined, that M_full=1, M_empty=1, then init 1->0 -> error_out=1 and errors=0.
